// File: rtl/fp_addsub_pipe_if.sv
// Operand/result channel of fp_addsub_pipe.
// valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
// the producer holds valid and its payload stable until that edge, and ready may depend on
// the consumer's state but never on the valid it is being offered.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, in_a, in_b, op_sub, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, in_a, in_b, op_sub, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style adder/subtractor: align, add, normalise/round.
// Subnormals are flushed to zero, rounding is nearest-even, flags are {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic             clk,
  input logic             rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;  // {hidden, frac, guard, round, sticky}
  localparam int SW = MAN_W + 5;  // MW plus carry out of the add
  localparam int EW = EXP_W + 2;  // signed working exponent

  localparam logic [EXP_W-1:0]    EXP_MAX = '1;
  localparam logic signed [EW-1:0] E_TOP  = $signed({2'b00, EXP_MAX});
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic int lzc(input logic [MW-1:0] v);
    lzc = MW;
    for (int i = 0; i < MW; i++) begin
      if (v[i]) lzc = MW - 1 - i;
    end
  endfunction

  // Global stall: every stage moves together or holds together.
  logic advance;
  logic v1, v2, v3;
  assign advance       = !v3 || bus.out_ready;
  assign bus.in_ready  = advance;

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  assign sa     = bus.in_a[W-1];
  assign sb     = bus.in_b[W-1] ^ bus.op_sub;  // sign of b as it enters the sum
  assign ea     = bus.in_a[W-2 -: EXP_W];
  assign eb     = bus.in_b[W-2 -: EXP_W];
  assign fa     = bus.in_a[MAN_W-1:0];
  assign fb     = bus.in_b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_MAX) && (fa == '0);
  assign b_inf  = (eb == EXP_MAX) && (fb == '0);
  assign a_nan  = (ea == EXP_MAX) && (fa != '0);
  assign b_nan  = (eb == EXP_MAX) && (fb != '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];

  logic         special_n;
  logic [W-1:0] spec_res_n;
  logic [3:0]   spec_flg_n;

  always_comb begin
    special_n  = 1'b1;
    spec_res_n = '0;
    spec_flg_n = '0;
    if (a_nan || b_nan) begin
      spec_res_n = QNAN;
      spec_flg_n = {a_snan || b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_res_n = QNAN;
      spec_flg_n = 4'b1000;
    end else if (a_inf) begin
      spec_res_n = bus.in_a;
    end else if (b_inf) begin
      spec_res_n = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      special_n = 1'b0;
    end
  end

  logic [W-2:0]     key_a, key_b;
  logic             swap;
  logic [EXP_W-1:0] ea_z, eb_z, ex_n, ey_n, diff;
  logic [MAN_W:0]   ma_h, mb_h, mx_h, my_h;
  logic             sx_n;

  assign key_a = a_zero ? '0 : bus.in_a[W-2:0];
  assign key_b = b_zero ? '0 : bus.in_b[W-2:0];
  assign swap  = key_b > key_a;
  assign ea_z  = a_zero ? '0 : ea;
  assign eb_z  = b_zero ? '0 : eb;
  assign ma_h  = a_zero ? '0 : {1'b1, fa};
  assign mb_h  = b_zero ? '0 : {1'b1, fb};
  assign ex_n  = swap ? eb_z : ea_z;
  assign ey_n  = swap ? ea_z : eb_z;
  assign mx_h  = swap ? mb_h : ma_h;
  assign my_h  = swap ? ma_h : mb_h;
  assign sx_n  = swap ? sb : sa;
  assign diff  = ex_n - ey_n;

  logic [2*MW-1:0] y_wide;
  logic [MW-1:0]   y_al;

  // Bits shifted past the sticky position are OR-ed into it.
  always_comb begin
    y_wide = {my_h, 3'b000, {MW{1'b0}}} >> diff;
    if (int'(diff) >= MAN_W + 3) begin
      y_al = {{(MW-1){1'b0}}, |my_h};
    end else begin
      y_al = {y_wide[2*MW-1:MW+1], y_wide[MW] | (|y_wide[MW-1:0])};
    end
  end

  logic             sp1, sx1, sub1, zs1;
  logic [W-1:0]     spr1;
  logic [3:0]       spf1;
  logic [EXP_W-1:0] ex1;
  logic [MW-1:0]    mx1, my1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      sp1  <= 1'b0;
      spr1 <= '0;
      spf1 <= '0;
      sx1  <= 1'b0;
      sub1 <= 1'b0;
      zs1  <= 1'b0;
      ex1  <= '0;
      mx1  <= '0;
      my1  <= '0;
    end else if (advance) begin
      v1   <= bus.in_valid;
      sp1  <= special_n;
      spr1 <= spec_res_n;
      spf1 <= spec_flg_n;
      sx1  <= sx_n;
      sub1 <= sa ^ sb;
      zs1  <= sa & sb;  // exact zero is negative only when both addends are -0
      ex1  <= ex_n;
      mx1  <= {mx_h, 3'b000};
      my1  <= y_al;
    end
  end

  // ---------------- S2: effective add / subtract ----------------
  logic             sp2, sx2, zs2;
  logic [W-1:0]     spr2;
  logic [3:0]       spf2;
  logic [EXP_W-1:0] ex2;
  logic [SW-1:0]    sum2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      sp2  <= 1'b0;
      spr2 <= '0;
      spf2 <= '0;
      sx2  <= 1'b0;
      zs2  <= 1'b0;
      ex2  <= '0;
      sum2 <= '0;
    end else if (advance) begin
      v2   <= v1;
      sp2  <= sp1;
      spr2 <= spr1;
      spf2 <= spf1;
      sx2  <= sx1;
      zs2  <= zs1;
      ex2  <= ex1;
      sum2 <= sub1 ? ({1'b0, mx1} - {1'b0, my1}) : ({1'b0, mx1} + {1'b0, my1});
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  int                     lz;
  logic [MW-1:0]          norm;
  logic signed [EW-1:0]   e_n, e_r;
  logic [MAN_W+1:0]       mant_r;
  logic [MAN_W-1:0]       frac_r;
  logic                   rup, inexact;
  logic [W-1:0]           res_n;
  logic [3:0]             flg_n;

  always_comb begin
    lz      = 0;
    norm    = '0;
    e_n     = $signed({2'b00, ex2});
    e_r     = '0;
    mant_r  = '0;
    frac_r  = '0;
    rup     = 1'b0;
    inexact = 1'b0;
    res_n   = '0;
    flg_n   = '0;

    if (sum2[SW-1]) begin
      norm = {sum2[SW-1:2], sum2[1] | sum2[0]};
      e_n  = e_n + E_ONE;
    end else begin
      lz   = lzc(sum2[MW-1:0]);
      norm = sum2[MW-1:0] << lz;
      e_n  = e_n - $signed(EW'(lz));
    end

    rup     = norm[2] & (norm[1] | norm[0] | norm[3]);
    inexact = norm[2] | norm[1] | norm[0];
    mant_r  = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
    if (mant_r[MAN_W+1]) begin
      e_r    = e_n + E_ONE;
      frac_r = mant_r[MAN_W:1];
    end else begin
      e_r    = e_n;
      frac_r = mant_r[MAN_W-1:0];
    end

    if (sp2) begin
      res_n = spr2;
      flg_n = spf2;
    end else if (sum2 == '0) begin
      res_n = {zs2, {(W-1){1'b0}}};
    end else if (e_r >= E_TOP) begin
      res_n = {sx2, EXP_MAX, {MAN_W{1'b0}}};
      flg_n = 4'b0101;
    end else if (e_r < E_ONE) begin
      res_n = {sx2, {(W-1){1'b0}}};
      flg_n = 4'b0011;
    end else begin
      res_n = {sx2, e_r[EXP_W-1:0], frac_r};
      flg_n = {3'b000, inexact};
    end
  end

  logic [W-1:0] result_r;
  logic [3:0]   flags_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3       <= 1'b0;
      result_r <= '0;
      flags_r  <= '0;
    end else if (advance) begin
      v3       <= v2;
      result_r <= res_n;
      flags_r  <= flg_n;
    end
  end

  assign bus.out_valid = v3;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: a driver pushes hand-computed results into a queue,
// a monitor pops and compares whenever a result is handed over.
module tb_fp_addsub_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000ns");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W+3:0] exp_q[$];
  int           tag_q[$];
  int           checks = 0;
  int           errors = 0;
  int           n_out  = 0;
  int           n_sent = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [W+3:0] e;
    int           t;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h/%b, expected no result", bus.result, bus.flags);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check($sformatf("vec%0d {result,flags}", t), {32'h0, bus.result, bus.flags}, {32'h0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic [W-1:0] r, input logic [3:0] f);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.op_sub   = sub;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({r, f});
        tag_q.push_back(n_sent);
        n_sent++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout vec%0d: got no in_ready in 200 cycles, expected acceptance", n_sent);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int n0, rel;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", bus.out_valid, 0);
    check("rst in_ready", bus.in_ready, 1);
    check("rst result", bus.result, 0);
    check("rst flags", bus.flags, 0);

    // First pair right after release, then watch the latency.
    rst = 1'b0;
    rel = cyc;
    send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    check("first_accept_edge", cyc - rel, 1);
    @(negedge clk);
    check("lat out_valid after accept edge", bus.out_valid, 0);
    @(negedge clk);
    check("lat out_valid after 2nd edge", bus.out_valid, 0);
    @(negedge clk);
    check("lat out_valid after 3rd edge", bus.out_valid, 1);
    drain();

    // Back-to-back directed vectors.
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);  // 1-1
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);  // -0 + -0
    send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);  // -0 - +0
    send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);  // +0 + -0
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);  // overflow
    send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);  // inf - inf
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);  // tie to even, down
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);  // tie to even, up
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);  // inf + finite
    send(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);  // finite + -inf
    send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);  // quiet NaN
    send(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);  // signalling NaN
    send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);  // 3-1
    send(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000);  // cancellation
    send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);  // underflow flush
    send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);  // subnormal as zero
    send(32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001);  // rounding carry
    send(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001);  // sticky-only shift
    send(32'h3F800000, 32'h00800000, 1'b1, 32'h3F800000, 4'b0001);  // sub with sticky
    send(32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 4'b0000);  // -1 - 1
    drain();

    // Back-pressure: four pairs against a stalled output.
    bus.out_ready = 1'b0;
    n0 = n_out;
    fork
      begin
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        send(32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 4'b0000);
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check($sformatf("stall in_ready k=%0d", k), bus.in_ready, (k < 3) ? 1 : 0);
          if (k >= 3) begin
            check($sformatf("stall out_valid k=%0d", k), bus.out_valid, 1);
            check($sformatf("stall held result k=%0d", k), {bus.result, bus.flags},
                  {32'h40400000, 4'b0000});
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall results delivered", n_out - n0, 4);

    // Reset with two operations in flight.
    bus.out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
    @(posedge clk);
    #1;
    check("pre-reset out_valid", bus.out_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    tag_q.delete();
    #1;
    check("mid-reset out_valid", bus.out_valid, 0);
    check("mid-reset in_ready", bus.in_ready, 1);
    check("mid-reset result", bus.result, 0);
    check("mid-reset flags", bus.flags, 0);
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    n0            = n_out;
    rel           = cyc;
    send(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);  // 2-1
    check("post-reset accept edge", cyc - rel, 1);
    drain();
    repeat (5) @(posedge clk);
    check("post-reset result count", n_out - n0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 The module SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The module SHALL have parameter MAN_W, default 23, meaning stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1, meaning operand pair present.
REQ-006 The module SHALL have port in_ready, output, 1, meaning operand pair accepted this cycle when in_valid is also high.
REQ-007 The module SHALL have ports in_a and in_b, input, W each, IEEE-754-style operands {sign, exp, frac}.
REQ-008 The module SHALL have port op_sub, input, 1, meaning 0 computes a+b and 1 computes a-b; sampled with the operands.
REQ-009 The module SHALL have port out_valid, output, 1, meaning result present.
REQ-010 The module SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-011 The module SHALL have port result, output, W, the rounded sum.
REQ-012 The module SHALL have port flags, output, 4, as {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-013 Three pipeline stages: S1 unpack, special-case detection, swap so |X|>=|Y|, align Y by exponent difference keeping guard, round and sticky bits; S2 effective add/subtract of (MAN_W+4)-bit mantissas; S3 leading-zero normalise, round, pack.
REQ-014 Latency SHALL be exactly 3 cycles from an in_valid&&in_ready edge to out_valid when out_ready stays high; throughput one result per cycle.
REQ-015 Global stall: advance = !out_valid || out_ready; in_ready SHALL equal advance; when advance is low, all stage registers hold their values.
REQ-016 Bubbles SHALL propagate as per-stage valid bits; results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-017 Effective subtraction SHALL occur when sign_a XOR sign_b XOR op_sub is 1.
REQ-018 Alignment shifts of MAN_W+3 or more SHALL collapse Y into sticky only.
REQ-019 Rounding SHALL be round-to-nearest-even using guard/round/sticky; a mantissa carry out of rounding increments the exponent.
REQ-020 inexact SHALL be 1 when any guard, round or sticky bit is nonzero before rounding.
REQ-021 Subnormal inputs (exp==0) SHALL be treated as signed zero; a result exponent below 1 SHALL flush to +/-0 with underflow=1 and inexact=1.
REQ-022 A result exponent at or above all-ones after rounding SHALL produce signed infinity with overflow=1 and inexact=1.
REQ-023 Any NaN input, or inf minus inf under the effective operation, SHALL produce canonical NaN {0, all-ones, 1 followed by zeros}; invalid=1 only for inf-inf or a signalling NaN (frac MSB 0).
REQ-024 Infinity with a finite operand SHALL return that infinity unchanged with all flags 0.
REQ-025 An exact zero sum SHALL be +0, except (-0)+(-0) and (-0)-(+0), which SHALL give -0.
REQ-026 When out_valid is high and out_ready is low, result and flags SHALL remain stable.

Reset
REQ-027 While rst is high, all stage valid bits and out_valid SHALL be 0; result and flags SHALL be 0; in_ready SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; no stale result SHALL appear after release.
REQ-029 The first operand pair SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-030 Send 0x3F800000 + 0x40000000, op_sub=0, out_ready=1 -> 0x40400000 three cycles later, flags=0000.
REQ-031 Send 0x3F800000 - 0x3F800000, op_sub=1 -> 0x00000000, flags=0000; with -0 + -0 -> 0x80000000.
REQ-032 Send 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=0101; send 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags=1000.
REQ-033 Send 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, flags=0001; send 0x3F800001 + 0x33800000 -> 0x3F800002, flags=0001.
REQ-034 Issue 4 back-to-back pairs, hold out_ready=0 for 6 cycles -> in_ready drops once 3 are in flight, result stays stable, all 4 results emerge in order with none lost after out_ready=1.
REQ-035 Assert rst with 2 operations in flight -> out_valid=0 immediately; after release, the next single pair is the only result produced.
